// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: request/response bundle between the ALU control unit,
// the execute stage and the writeback path.
// master = upstream/writeback side, slave = execute stage.
interface alu_exec_stage_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALUCtrl;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             carry;
   logic             ovf;
   logic             illegal;

   modport master (
      output in_valid, ALUCtrl, a, b, out_ready,
      input  in_ready, out_valid, result, zero, carry, ovf, illegal
   );

   modport slave (
      input  in_valid, ALUCtrl, a, b, out_ready,
      output in_ready, out_valid, result, zero, carry, ovf, illegal
   );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with valid/ready on both sides.
// Single-cycle ops load the result register directly. The iterative
// shift-add multiplier is compiled in only when ALU_MUL_EN is defined;
// otherwise opcode 1010 is reported as illegal like 1100-1111.
module alu_exec_stage #(
   parameter int WIDTH = 16
) (
   input  logic            clk,
   input  logic            rst,
   alu_exec_stage_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NOR   = 4'b0101;
   localparam logic [3:0] OP_SLT   = 4'b0110;
   localparam logic [3:0] OP_SLL   = 4'b0111;
   localparam logic [3:0] OP_SRL   = 4'b1000;
   localparam logic [3:0] OP_SRA   = 4'b1001;
   localparam logic [3:0] OP_PASSB = 4'b1011;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL   = 4'b1010;
`endif

   typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t           r_state;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_carry;
   logic             r_ovf;
   logic             r_illegal;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [SHW-1:0]   r_count;
   logic [WIDTH-1:0] w_acc_next;
`endif

   logic             w_in_ready;
   logic             w_in_fire;
   logic             w_out_fire;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_result;
   logic             w_carry;
   logic             w_ovf;
   logic             w_illegal;
   logic             w_zero;

   // Input may be taken only in IDLE and only if the result slot frees up this cycle.
   assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
   assign w_in_fire  = bus.in_valid && w_in_ready;
   assign w_out_fire = r_out_valid && bus.out_ready;

   assign w_sum   = {1'b0, bus.a} + {1'b0, bus.b};
   assign w_diff  = {1'b0, bus.a} - {1'b0, bus.b};
   assign w_shamt = bus.b[SHW-1:0];

`ifdef ALU_MUL_EN
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

   // Single-cycle result and flags; unassigned codes give 0 with only illegal set.
   always_comb begin
      w_result  = '0;
      w_carry   = 1'b0;
      w_ovf     = 1'b0;
      w_illegal = 1'b0;
      case (bus.ALUCtrl)
         OP_ADD: begin
            w_result = w_sum[WIDTH-1:0];
            w_carry  = w_sum[WIDTH];
            w_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            w_result = w_diff[WIDTH-1:0];
            w_carry  = !w_diff[WIDTH];
            w_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND:   w_result = bus.a & bus.b;
         OP_OR:    w_result = bus.a | bus.b;
         OP_XOR:   w_result = bus.a ^ bus.b;
         OP_NOR:   w_result = ~(bus.a | bus.b);
         OP_SLT:   w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLL:   w_result = bus.a << w_shamt;
         OP_SRL:   w_result = bus.a >> w_shamt;
         OP_SRA:   w_result = WIDTH'($signed(bus.a) >>> w_shamt);
         OP_PASSB: w_result = bus.b;
         default:  w_illegal = 1'b1;
      endcase
   end

   // An illegal op reports all flags other than illegal as 0, including zero.
   assign w_zero = (w_result == '0) && !w_illegal;

   // Control FSM plus output and multiplier registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
         r_illegal   <= 1'b0;
`ifdef ALU_MUL_EN
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_count     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_out_fire) begin
                  r_out_valid <= 1'b0;
               end
               if (w_in_fire) begin
`ifdef ALU_MUL_EN
                  if (bus.ALUCtrl == OP_MUL) begin
                     r_mcand     <= bus.a;
                     r_mplier    <= bus.b;
                     r_acc       <= '0;
                     r_count     <= '0;
                     r_out_valid <= 1'b0;
                     r_state     <= S_MUL;
                  end else
`endif
                  begin
                     r_result    <= w_result;
                     r_zero      <= w_zero;
                     r_carry     <= w_carry;
                     r_ovf       <= w_ovf;
                     r_illegal   <= w_illegal;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            default: begin
`ifdef ALU_MUL_EN
               // One shift-add step per cycle; the last step writes the result directly.
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               if (r_count == SHW'(WIDTH - 1)) begin
                  r_result    <= w_acc_next;
                  r_zero      <= (w_acc_next == '0);
                  r_carry     <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_illegal   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_IDLE;
               end
`else
               r_state <= S_IDLE;
`endif
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.carry     = r_carry;
   assign bus.ovf       = r_ovf;
   assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table for single-cycle ops (applied
// back-to-back), plus hand sequences for backpressure, multiply and reset
// abort. Works with and without ALU_MUL_EN defined.
module tb_alu_exec_stage;
   localparam int WIDTH = 16;

   logic clk;
   logic rst;

   alu_exec_stage_if #(.WIDTH(WIDTH)) bus ();

   alu_exec_stage #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctrl;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        z;
      logic        c;
      logic        v;
      logic        ill;
   } vec_t;

   vec_t vecs[$];
   int   n_applied = 0;
   int   n_miscompare = 0;

   function automatic vec_t mk(logic [3:0] ctrl, logic [15:0] a, logic [15:0] b,
                               logic [15:0] res, logic z, logic c, logic v, logic ill);
      vec_t t;
      t.ctrl = ctrl; t.a = a; t.b = b; t.res = res;
      t.z = z; t.c = c; t.v = v; t.ill = ill;
      return t;
   endfunction

   // {out_valid, result, zero, carry, ovf, illegal}
   function automatic logic [20:0] obs();
      return {bus.out_valid, bus.result, bus.zero, bus.carry, bus.ovf, bus.illegal};
   endfunction

   function automatic logic [20:0] expv(vec_t t);
      return {1'b1, t.res, t.z, t.c, t.v, t.ill};
   endfunction

   task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscompare++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b);
      bus.in_valid = 1'b1;
      bus.ALUCtrl  = ctrl;
      bus.a        = a;
      bus.b        = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Single-cycle vector table: ctrl, a, b, result, zero, carry, ovf, illegal
      vecs.push_back(mk(4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 0));
      vecs.push_back(mk(4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0));
      vecs.push_back(mk(4'b0000, 16'h8000, 16'h8000, 16'h0000, 1, 1, 1, 0));
      vecs.push_back(mk(4'b0001, 16'h0005, 16'h0005, 16'h0000, 1, 1, 0, 0));
      vecs.push_back(mk(4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0, 0));
      vecs.push_back(mk(4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 1, 0));
      vecs.push_back(mk(4'b0010, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0));
      vecs.push_back(mk(4'b0011, 16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 0, 0, 0));
      vecs.push_back(mk(4'b0100, 16'hAAAA, 16'hFFFF, 16'h5555, 0, 0, 0, 0));
      vecs.push_back(mk(4'b0101, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 0, 0));
      vecs.push_back(mk(4'b0101, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0, 0));
      vecs.push_back(mk(4'b0110, 16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0, 0));
      vecs.push_back(mk(4'b0110, 16'h0001, 16'hFFFF, 16'h0000, 1, 0, 0, 0));
      vecs.push_back(mk(4'b0111, 16'h0001, 16'h0013, 16'h0008, 0, 0, 0, 0));
      vecs.push_back(mk(4'b1000, 16'h8000, 16'h0004, 16'h0800, 0, 0, 0, 0));
      vecs.push_back(mk(4'b1001, 16'h8000, 16'h0004, 16'hF800, 0, 0, 0, 0));
      vecs.push_back(mk(4'b1001, 16'h8000, 16'h000F, 16'hFFFF, 0, 0, 0, 0));
      vecs.push_back(mk(4'b1001, 16'h4000, 16'h0002, 16'h1000, 0, 0, 0, 0));
      vecs.push_back(mk(4'b1011, 16'hDEAD, 16'h1234, 16'h1234, 0, 0, 0, 0));
      vecs.push_back(mk(4'b1100, 16'h1234, 16'h5678, 16'h0000, 0, 0, 0, 1));
      vecs.push_back(mk(4'b1110, 16'h1234, 16'h5678, 16'h0000, 0, 0, 0, 1));
      vecs.push_back(mk(4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 0, 1));
`ifndef ALU_MUL_EN
      vecs.push_back(mk(4'b1010, 16'h0012, 16'h0034, 16'h0000, 0, 0, 0, 1));
`endif

      bus.in_valid  = 1'b0;
      bus.ALUCtrl   = 4'b0000;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", obs(), 21'h0);
      rst = 1'b0;
      tick();
      check("reset_in_ready", 21'(bus.in_ready), 21'h1);

      // Back-to-back table: one op per cycle with out_ready held high.
      drive(vecs[0].ctrl, vecs[0].a, vecs[0].b);
      for (int i = 0; i < vecs.size(); i++) begin
         tick();
         $display("vec %0d ctrl=%b a=%h b=%h -> result=%h z=%b c=%b v=%b ill=%b",
                  i, vecs[i].ctrl, vecs[i].a, vecs[i].b,
                  bus.result, bus.zero, bus.carry, bus.ovf, bus.illegal);
         check($sformatf("vec%0d", i), obs(), expv(vecs[i]));
         if (i + 1 < vecs.size()) drive(vecs[i+1].ctrl, vecs[i+1].a, vecs[i+1].b);
         else bus.in_valid = 1'b0;
      end
      tick();
      check("drain_idle", 21'(bus.out_valid), 21'h0);

      // Backpressure: ADD 2+3 held for 3 cycles while a SUB waits upstream.
      bus.out_ready = 1'b0;
      drive(4'b0000, 16'h0002, 16'h0003);
      tick();
      drive(4'b0001, 16'h0009, 16'h0002);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("hold%0d_out", k), obs(), {1'b1, 16'h0005, 4'b0000});
         check($sformatf("hold%0d_in_ready", k), 21'(bus.in_ready), 21'h0);
         tick();
      end
      $display("backpressure held result=%h", bus.result);
      bus.out_ready = 1'b1;
      #1;
      check("release_in_ready", 21'(bus.in_ready), 21'h1);
      tick();
      bus.in_valid = 1'b0;
      $display("drain+accept result=%h", bus.result);
      check("drain_accept", obs(), {1'b1, 16'h0007, 4'b0100});
      tick();
      check("after_drain", 21'(bus.out_valid), 21'h0);

`ifdef ALU_MUL_EN
      // Multiply: input blocked 16 cycles, result visible 17 cycles after accept.
      drive(4'b1010, 16'h0012, 16'h0034);
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         check($sformatf("mul_busy%0d", k), {19'h0, bus.in_ready, bus.out_valid}, 21'h0);
         tick();
      end
      $display("mul 0012*0034 result=%h", bus.result);
      check("mul_result", obs(), {1'b1, 16'h03A8, 4'b0000});
      check("mul_in_ready", 21'(bus.in_ready), 21'h1);
      tick();
      // Multiply whose low 16 bits are zero.
      drive(4'b1010, 16'h0100, 16'h0100);
      tick();
      bus.in_valid = 1'b0;
      repeat (WIDTH) tick();
      check("mul_zero", obs(), {1'b1, 16'h0000, 4'b1000});
      tick();
`endif

      // Reset abort: start an op (MUL if present), then reset 5 cycles in.
      bus.out_ready = 1'b0;
`ifdef ALU_MUL_EN
      drive(4'b1010, 16'h0012, 16'h0034);
`else
      drive(4'b0000, 16'h1111, 16'h2222);
`endif
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      $display("reset mid-op out_valid=%b result=%h", bus.out_valid, bus.result);
      check("abort_outputs", obs(), 21'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("abort_in_ready", 21'(bus.in_ready), 21'h1);
      bus.out_ready = 1'b1;
      drive(4'b0000, 16'h0100, 16'h0200);
      tick();
      bus.in_valid = 1'b0;
      $display("post-reset add result=%h", bus.result);
      check("post_reset_add", obs(), {1'b1, 16'h0300, 4'b0000});
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
      $finish;
   end
endmodule
